id_ex_stage: RTL

ID/EX pipeline register for the 5-stage RISC-V core, with load-use hazard detection and bubble insertion. It captures the decoded instruction from ID and presents it to EX, where the forwarding unit consumes `ex_rs1`, `ex_rs2` and the bypass muxes consume `ex_rs1_data` and `ex_rs2_data`. It also resolves register-file write-during-read against WB, and applies the EX branch flush.

---
 rtl/id_ex_pkg.sv | 26 ++
 rtl/id_ex_stage_hazard.sv | 28 ++
 rtl/id_ex_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
// Shared constants for the ID/EX pipeline register: widths, the bubble
// control bundle and the control-bundle field layout.
package id_ex_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int REG_W  = 5;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    localparam int CTRL_ALUOP_LSB = 0;
    localparam int CTRL_ALUOP_W   = 4;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_MEMTOREG  = 6;
    localparam int CTRL_BRANCH    = 7;

    // A match on x0 never counts: x0 is hardwired and has no producer.
    function automatic logic reg_hit(
        input logic [REG_W-1:0] a,
        input logic [REG_W-1:0] b
    );
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detector: combinational lu/stall_if from the
// registered EX state and the instruction currently in ID.
module hazard_detect
    import id_ex_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_flush,
    output logic             lu,
    output logic             stall_if
);

    logic w_src_hit;

    assign w_src_hit = reg_hit(ex_rd, id_rs1)
                     | reg_hit(ex_rd, id_rs2);

    assign lu = ex_valid & ex_memread
              & id_valid & w_src_hit;

    // A flushed ID instruction is discarded, so holding it is pointless.
    assign stall_if = lu & ~ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, WB write-during-read
// bypass and EX flush. Optional counters under ID_EX_PERF_EN.
module id_ex_stage
    import id_ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall_if,
`ifdef ID_EX_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [REG_W-1:0]  r_rs1;
    logic [REG_W-1:0]  r_rs2;
    logic [REG_W-1:0]  r_rd;
    logic              r_regwrite;
    logic              r_memread;
    logic [CTRL_W-1:0] r_ctrl;

    logic              w_lu;
    logic              w_stall;
    logic              w_load;
    logic [XLEN-1:0]   w_rs1_byp;
    logic [XLEN-1:0]   w_rs2_byp;

    logic              w_valid;
    logic [XLEN-1:0]   w_pc;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_rs1_data;
    logic [XLEN-1:0]   w_rs2_data;
    logic [REG_W-1:0]  w_rs1;
    logic [REG_W-1:0]  w_rs2;
    logic [REG_W-1:0]  w_rd;
    logic              w_regwrite;
    logic              w_memread;
    logic [CTRL_W-1:0] w_ctrl;

    hazard_detect u_hazard (
        .ex_valid   (r_valid),
        .ex_memread (r_memread),
        .ex_rd      (r_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_flush   (ex_flush),
        .lu         (w_lu),
        .stall_if   (w_stall)
    );

    assign stall_if = w_stall;
    assign w_load   = ~ex_flush & ~w_lu;

    // The register file writes at the clock edge, so ID reads stale data.
    assign w_rs1_byp = (wb_regwrite && reg_hit(wb_rd, id_rs1))
                     ? wb_data : id_rs1_data;
    assign w_rs2_byp = (wb_regwrite && reg_hit(wb_rd, id_rs2))
                     ? wb_data : id_rs2_data;

    always_comb begin
        w_valid    = 1'b0;
        w_pc       = '0;
        w_imm      = '0;
        w_rs1_data = '0;
        w_rs2_data = '0;
        w_rs1      = '0;
        w_rs2      = '0;
        w_rd       = '0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_ctrl     = CTRL_NOP;
        if (w_load) begin
            w_valid    = id_valid;
            w_pc       = id_pc;
            w_imm      = id_imm;
            w_rs1_data = w_rs1_byp;
            w_rs2_data = w_rs2_byp;
            w_rs1      = id_rs1;
            w_rs2      = id_rs2;
            w_rd       = id_rd;
            w_regwrite = id_valid & id_regwrite;
            w_memread  = id_valid & id_memread;
            w_ctrl     = id_valid ? id_ctrl : CTRL_NOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_ctrl     <= CTRL_NOP;
        end else begin
            r_valid    <= w_valid;
            r_pc       <= w_pc;
            r_imm      <= w_imm;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= w_rd;
            r_regwrite <= w_regwrite;
            r_memread  <= w_memread;
            r_ctrl     <= w_ctrl;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_imm      = r_imm;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_regwrite = r_regwrite;
    assign ex_memread  = r_memread;
    assign ex_ctrl     = r_ctrl;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (ex_flush)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
